baw_round_ctrl: RTL and testbench

- Round sequencer for the black-and-white card game: owns the turn order, card-selection handshake, comparator strobe, score counters and game-finish detection.
- Sits between the button/switch inputs and the comparator datapath. Drives the latched player cards, samples the comparator's match result, and feeds the display with state, round and score.

---
 rtl/baw_round_ctrl_if.sv | 47 ++++
 rtl/baw_round_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_baw_round_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/baw_round_ctrl_if.sv
// Button, switch, comparator and display bundle for the round sequencer.
// slave: sequencer side; master: panel/comparator/display side.
interface baw_round_ctrl_if #(
    parameter int CARDS = 9
);
    logic             clr;
    logic             btn_start;
    logic             btn_p1;
    logic             btn_p2;
    logic             btn_confirm;
    logic             btn_next;
    logic [CARDS-1:0] sel;
    logic [1:0]       match_result;
    logic [2:0]       state;
    logic [3:0]       p1_card;
    logic [3:0]       p2_card;
    logic             p1_locked;
    logic             p2_locked;
    logic             cmp_strobe;
    logic             score_pulse;
    logic             sel_err;
    logic [3:0]       round;
    logic [3:0]       p1_wins;
    logic [3:0]       p2_wins;
    logic [CARDS-1:0] p1_used;
    logic [CARDS-1:0] p2_used;
    logic             finish;
    logic [1:0]       game_result;

    modport slave (
        input  clr, btn_start, btn_p1, btn_p2, btn_confirm, btn_next,
        input  sel, match_result,
        output state, p1_card, p2_card, p1_locked, p2_locked,
        output cmp_strobe, score_pulse, sel_err,
        output round, p1_wins, p2_wins, p1_used, p2_used,
        output finish, game_result
    );

    modport master (
        output clr, btn_start, btn_p1, btn_p2, btn_confirm, btn_next,
        output sel, match_result,
        input  state, p1_card, p2_card, p1_locked, p2_locked,
        input  cmp_strobe, score_pulse, sel_err,
        input  round, p1_wins, p2_wins, p1_used, p2_used,
        input  finish, game_result
    );
endinterface

// File: rtl/baw_round_ctrl.sv
// Black-and-white card game round sequencer: turn order, card locking,
// compare strobe, score counters and game-over detection.
// Ports: clk, resetn (async, active low), bus (baw_round_ctrl_if.slave).
module baw_round_ctrl #(
    parameter int CARDS      = 9,
    parameter int ROUNDS     = 9,
    parameter int WIN_TARGET = 5
) (
    input  logic             clk,
    input  logic             resetn,
    baw_round_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READY   = 3'd1,
        P1_SEL  = 3'd2,
        P2_SEL  = 3'd3,
        COMPARE = 3'd4,
        SCORE   = 3'd5,
        SHOW    = 3'd6,
        DONE    = 3'd7
    } stateT;

    stateT            curState;
    stateT            nxtState;

    logic [4:0]       btnNow;
    logic [4:0]       btnPrev;
    logic [4:0]       btnEdge;

    logic [3:0]       p1Card;
    logic [3:0]       p2Card;
    logic             p1Lock;
    logic             p2Lock;
    logic [3:0]       roundCnt;
    logic [3:0]       p1Wins;
    logic [3:0]       p2Wins;
    logic [CARDS-1:0] p1Used;
    logic [CARDS-1:0] p2Used;
    logic             finishQ;
    logic [1:0]       resultQ;

    logic [3:0]       selIdx;
    logic             selOneHot;
    logic             p1Ok;
    logic             p2Ok;
    logic             finishNow;

    logic             newGame;
    logic             lock1;
    logic             lock2;
    logic             doScore;
    logic             inShow;
    logic             unlock;
    logic             endGame;
    logic             cmpStrobe;
    logic             selErr;

    assign btnNow = {bus.btn_next, bus.btn_confirm, bus.btn_p2,
                     bus.btn_p1, bus.btn_start};
    assign btnEdge = btnNow & ~btnPrev;

    always_comb begin
        selIdx = '0;
        for (int i = 0; i < CARDS; i++) begin
            if (bus.sel[i]) selIdx = 4'(i);
        end
    end

    assign selOneHot = $onehot(bus.sel);
    assign p1Ok = selOneHot && ((bus.sel & p1Used) == '0);
    assign p2Ok = selOneHot && ((bus.sel & p2Used) == '0);

    assign finishNow = (p1Wins == 4'(WIN_TARGET)) |
                       (p2Wins == 4'(WIN_TARGET)) |
                       (roundCnt == 4'(ROUNDS));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) curState <= IDLE;
        else         curState <= nxtState;
    end

    always_comb begin
        nxtState  = curState;
        newGame   = 1'b0;
        lock1     = 1'b0;
        lock2     = 1'b0;
        doScore   = 1'b0;
        inShow    = 1'b0;
        unlock    = 1'b0;
        endGame   = 1'b0;
        cmpStrobe = 1'b0;
        selErr    = 1'b0;
        if (bus.clr) begin
            nxtState = IDLE;
        end else begin
            unique case (curState)
                IDLE, DONE: begin
                    if (btnEdge[0]) begin
                        newGame  = 1'b1;
                        nxtState = READY;
                    end
                end
                READY: begin
                    // lock states make these three mutually exclusive
                    if (btnEdge[1] && !p1Lock)
                        nxtState = P1_SEL;
                    else if (btnEdge[2] && p1Lock && !p2Lock)
                        nxtState = P2_SEL;
                    else if (btnEdge[3] && p1Lock && p2Lock)
                        nxtState = COMPARE;
                end
                P1_SEL: begin
                    if (btnEdge[3]) begin
                        if (p1Ok) begin
                            lock1    = 1'b1;
                            nxtState = READY;
                        end else begin
                            selErr = 1'b1;
                        end
                    end
                end
                P2_SEL: begin
                    if (btnEdge[3]) begin
                        if (p2Ok) begin
                            lock2    = 1'b1;
                            nxtState = READY;
                        end else begin
                            selErr = 1'b1;
                        end
                    end
                end
                COMPARE: begin
                    cmpStrobe = 1'b1;
                    nxtState  = SCORE;
                end
                SCORE: begin
                    doScore  = 1'b1;
                    nxtState = SHOW;
                end
                SHOW: begin
                    inShow = 1'b1;
                    if (btnEdge[4]) begin
                        if (finishNow) begin
                            endGame  = 1'b1;
                            nxtState = DONE;
                        end else begin
                            unlock   = 1'b1;
                            nxtState = READY;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btnPrev  <= '0;
            p1Card   <= '0;
            p2Card   <= '0;
            p1Lock   <= 1'b0;
            p2Lock   <= 1'b0;
            roundCnt <= '0;
            p1Wins   <= '0;
            p2Wins   <= '0;
            p1Used   <= '0;
            p2Used   <= '0;
            finishQ  <= 1'b0;
            resultQ  <= '0;
        end else if (bus.clr) begin
            btnPrev  <= '0;
            p1Card   <= '0;
            p2Card   <= '0;
            p1Lock   <= 1'b0;
            p2Lock   <= 1'b0;
            roundCnt <= '0;
            p1Wins   <= '0;
            p2Wins   <= '0;
            p1Used   <= '0;
            p2Used   <= '0;
            finishQ  <= 1'b0;
            resultQ  <= '0;
        end else begin
            btnPrev <= btnNow;
            if (newGame) begin
                p1Card   <= '0;
                p2Card   <= '0;
                p1Lock   <= 1'b0;
                p2Lock   <= 1'b0;
                roundCnt <= '0;
                p1Wins   <= '0;
                p2Wins   <= '0;
                p1Used   <= '0;
                p2Used   <= '0;
                finishQ  <= 1'b0;
                resultQ  <= '0;
            end
            if (lock1) begin
                p1Card <= selIdx;
                p1Lock <= 1'b1;
            end
            if (lock2) begin
                p2Card <= selIdx;
                p2Lock <= 1'b1;
            end
            if (doScore) begin
                unique case (1'b1)
                    bus.match_result == 2'b01:
                        if (p1Wins != 4'(WIN_TARGET)) p1Wins <= p1Wins + 4'd1;
                    bus.match_result == 2'b10:
                        if (p2Wins != 4'(WIN_TARGET)) p2Wins <= p2Wins + 4'd1;
                    default: ;
                endcase
                if (roundCnt != 4'(ROUNDS)) roundCnt <= roundCnt + 4'd1;
                p1Used <= p1Used | (CARDS'(1) << p1Card);
                p2Used <= p2Used | (CARDS'(1) << p2Card);
            end
            if (inShow) finishQ <= finishNow;
            if (unlock) begin
                // cards stay latched so the display keeps the last play
                p1Lock <= 1'b0;
                p2Lock <= 1'b0;
            end
            if (endGame) begin
                if (p1Wins > p2Wins)      resultQ <= 2'b01;
                else if (p2Wins > p1Wins) resultQ <= 2'b10;
                else                      resultQ <= 2'b00;
            end
        end
    end

    assign bus.state       = curState;
    assign bus.p1_card     = p1Card;
    assign bus.p2_card     = p2Card;
    assign bus.p1_locked   = p1Lock;
    assign bus.p2_locked   = p2Lock;
    assign bus.cmp_strobe  = cmpStrobe;
    assign bus.score_pulse = doScore;
    assign bus.sel_err     = selErr;
    assign bus.round       = roundCnt;
    assign bus.p1_wins     = p1Wins;
    assign bus.p2_wins     = p2Wins;
    assign bus.p1_used     = p1Used;
    assign bus.p2_used     = p2Used;
    assign bus.finish      = finishQ;
    assign bus.game_result = resultQ;
endmodule

// File: tb/tb_baw_round_ctrl.sv
// Bench for baw_round_ctrl: directed game scenarios plus random button
// traffic, checked every cycle against a behavioural game model.
module tb_baw_round_ctrl;
    localparam int CARDS = 9;
    localparam int ROUNDS = 9;
    localparam int WIN = 5;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic clr = 1'b0;
    logic [4:0] btns = '0;
    logic [CARDS-1:0] sel = '0;
    logic [1:0] match = '0;

    int checks = 0;
    int failures = 0;
    int nCmp = 0;
    int nScore = 0;
    int nErr = 0;

    int mSt, mP1c, mP2c, mRnd, mW1, mW2, mRes;
    bit mL1, mL2, mFin;
    logic [CARDS-1:0] mU1, mU2;
    logic [4:0] mPrev;

    baw_round_ctrl_if #(.CARDS(CARDS)) bus ();

    assign bus.clr = clr;
    assign bus.btn_start = btns[0];
    assign bus.btn_p1 = btns[1];
    assign bus.btn_p2 = btns[2];
    assign bus.btn_confirm = btns[3];
    assign bus.btn_next = btns[4];
    assign bus.sel = sel;
    assign bus.match_result = match;

    baw_round_ctrl #(
        .CARDS(CARDS),
        .ROUNDS(ROUNDS),
        .WIN_TARGET(WIN)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic clearGame();
        mP1c = 0; mP2c = 0; mL1 = 0; mL2 = 0;
        mRnd = 0; mW1 = 0; mW2 = 0;
        mU1 = '0; mU2 = '0; mFin = 0; mRes = 0;
    endtask

    initial begin
        mSt = 0; mPrev = '0;
        clearGame();
    end

    // Model: compare this cycle's outputs, then advance one clock.
    always @(negedge clk) begin : cmpProc
        logic [4:0] e;
        int idx;
        bit okSel, ok1, ok2, live, fc;
        int expErr;
        if (!resetn) begin
            mSt = 0; mPrev = '0;
            clearGame();
        end
        e = btns & ~mPrev;
        okSel = ($countones(sel) == 1);
        idx = 0;
        for (int i = 0; i < CARDS; i++) if (sel[i]) idx = i;
        ok1 = okSel && ((sel & mU1) == '0);
        ok2 = okSel && ((sel & mU2) == '0);
        live = resetn && !clr;
        expErr = (live && e[3] &&
                  ((mSt == 2 && !ok1) || (mSt == 3 && !ok2))) ? 1 : 0;

        chk("state", int'(bus.state), mSt);
        chk("p1_card", int'(bus.p1_card), mP1c);
        chk("p2_card", int'(bus.p2_card), mP2c);
        chk("p1_locked", int'(bus.p1_locked), int'(mL1));
        chk("p2_locked", int'(bus.p2_locked), int'(mL2));
        chk("cmp_strobe", int'(bus.cmp_strobe), (live && mSt == 4) ? 1 : 0);
        chk("score_pulse", int'(bus.score_pulse), (live && mSt == 5) ? 1 : 0);
        chk("sel_err", int'(bus.sel_err), expErr);
        chk("round", int'(bus.round), mRnd);
        chk("p1_wins", int'(bus.p1_wins), mW1);
        chk("p2_wins", int'(bus.p2_wins), mW2);
        chk("p1_used", int'(bus.p1_used), int'(mU1));
        chk("p2_used", int'(bus.p2_used), int'(mU2));
        chk("finish", int'(bus.finish), int'(mFin));
        if (mFin) chk("game_result", int'(bus.game_result), mRes);

        nCmp += int'(bus.cmp_strobe);
        nScore += int'(bus.score_pulse);
        nErr += int'(bus.sel_err);

        if (!live) begin
            mSt = 0; mPrev = '0;
            clearGame();
        end else begin
            mPrev = btns;
            case (mSt)
                0, 7: if (e[0]) begin clearGame(); mSt = 1; end
                1: begin
                    if (e[1] && !mL1) mSt = 2;
                    else if (e[2] && mL1 && !mL2) mSt = 3;
                    else if (e[3] && mL1 && mL2) mSt = 4;
                end
                2: if (e[3] && ok1) begin mP1c = idx; mL1 = 1; mSt = 1; end
                3: if (e[3] && ok2) begin mP2c = idx; mL2 = 1; mSt = 1; end
                4: mSt = 5;
                5: begin
                    if (match == 2'b01) mW1++;
                    if (match == 2'b10) mW2++;
                    mRnd++;
                    mU1[mP1c] = 1'b1;
                    mU2[mP2c] = 1'b1;
                    mSt = 6;
                end
                6: begin
                    fc = (mW1 == WIN) || (mW2 == WIN) || (mRnd == ROUNDS);
                    mFin = fc;
                    if (e[4]) begin
                        if (fc) begin
                            mRes = (mW1 > mW2) ? 1 : ((mW2 > mW1) ? 2 : 0);
                            mSt = 7;
                        end else begin
                            mL1 = 0; mL2 = 0; mSt = 1;
                        end
                    end
                end
                default: mSt = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(int b);
        btns[b] = 1'b1;
        tick();
        btns[b] = 1'b0;
        tick();
    endtask

    task automatic pick(int p, int card);
        press(p);
        sel = '0;
        sel[card] = 1'b1;
        press(3);
    endtask

    task automatic playRound(int c1, int c2, logic [1:0] mr);
        pick(1, c1);
        pick(2, c2);
        match = mr;
        press(3);
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_state", int'(bus.state), 0);
        chk("rst_round", int'(bus.round), 0);
        chk("rst_finish", int'(bus.finish), 0);
        resetn = 1'b1;
        tick();

        // basic round, p2 wins
        press(0);
        nCmp = 0; nScore = 0;
        playRound(2, 5, 2'b10);
        chk("s1_state", int'(bus.state), 6);
        chk("s1_p2_wins", int'(bus.p2_wins), 1);
        chk("s1_p1_wins", int'(bus.p1_wins), 0);
        chk("s1_round", int'(bus.round), 1);
        chk("s1_p1_used", int'(bus.p1_used), 'h004);
        chk("s1_p2_used", int'(bus.p2_used), 'h020);
        chk("s1_cmp_cnt", nCmp, 1);
        chk("s1_score_cnt", nScore, 1);

        // ignored edges and rejected selections
        press(4);
        press(2);
        chk("s2_p2_early", int'(bus.state), 1);
        press(1);
        nErr = 0;
        sel = 'h006;
        press(3);
        sel = '0;
        press(3);
        chk("s2_err_cnt", nErr, 2);
        chk("s2_state", int'(bus.state), 2);
        chk("s2_p1_locked", int'(bus.p1_locked), 0);
        sel = 'h004;
        press(3);
        chk("s2_replay_err", nErr, 3);
        chk("s2_replay_state", int'(bus.state), 2);
        sel = 'h008;
        btns[3] = 1'b1;
        repeat (5) tick();
        btns[3] = 1'b0;
        tick();
        chk("s2_held_state", int'(bus.state), 1);
        chk("s2_held_card", int'(bus.p1_card), 3);
        chk("s2_held_err", nErr, 3);
        press(3);
        chk("s2_cfm_early", int'(bus.state), 1);
        pick(2, 2);
        match = 2'b01;
        press(3);
        tick();
        chk("s2_p1_wins", int'(bus.p1_wins), 1);
        chk("s2_round", int'(bus.round), 2);
        chk("s2_p1_used", int'(bus.p1_used), 'h00C);
        chk("s2_p2_used", int'(bus.p2_used), 'h024);

        // p1 reaches the win target
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("s3_clr_state", int'(bus.state), 0);
        chk("s3_clr_used", int'(bus.p1_used), 0);
        press(0);
        for (int i = 0; i < 5; i++) begin
            playRound(i, i, 2'b01);
            press(4);
        end
        chk("s3_finish", int'(bus.finish), 1);
        chk("s3_state", int'(bus.state), 7);
        chk("s3_result", int'(bus.game_result), 1);
        chk("s3_round", int'(bus.round), 5);

        // nine drawn rounds
        press(0);
        chk("s4_new_round", int'(bus.round), 0);
        chk("s4_new_wins", int'(bus.p1_wins), 0);
        chk("s4_new_used", int'(bus.p1_used), 0);
        chk("s4_new_finish", int'(bus.finish), 0);
        for (int i = 0; i < 9; i++) begin
            playRound(i, 8 - i, (i % 2) ? 2'b11 : 2'b00);
            press(4);
        end
        chk("s4_round", int'(bus.round), 9);
        chk("s4_wins", int'(bus.p1_wins) + int'(bus.p2_wins), 0);
        chk("s4_state", int'(bus.state), 7);
        chk("s4_result", int'(bus.game_result), 0);
        chk("s4_p1_used", int'(bus.p1_used), 'h1FF);
        press(0);
        chk("s4_restart", int'(bus.state), 1);
        chk("s4_re_round", int'(bus.round), 0);
        chk("s4_re_used", int'(bus.p2_used), 0);

        // clr while scoring
        pick(1, 1);
        pick(2, 1);
        match = 2'b01;
        press(3);
        chk("s5_in_score", int'(bus.state), 5);
        nScore = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("s5_no_pulse", nScore, 0);
        chk("s5_state", int'(bus.state), 0);
        chk("s5_p1_wins", int'(bus.p1_wins), 0);
        chk("s5_round", int'(bus.round), 0);

        // async reset during p2 selection
        press(0);
        pick(1, 7);
        press(2);
        chk("s6_p2sel", int'(bus.state), 3);
        resetn = 1'b0;
        #1;
        chk("s6_rst_state", int'(bus.state), 0);
        chk("s6_rst_lock", int'(bus.p1_locked), 0);
        chk("s6_rst_card", int'(bus.p1_card), 0);
        tick();
        resetn = 1'b1;
        tick();

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 5; b++) btns[b] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) begin
                sel = '0;
                sel[$urandom_range(0, CARDS - 1)] = 1'b1;
            end else begin
                sel = CARDS'($urandom);
            end
            match = 2'($urandom);
            clr = ($urandom_range(0, 149) == 0);
            resetn = ($urandom_range(0, 299) != 0);
            tick();
        end
        btns = '0;
        clr = 1'b0;
        resetn = 1'b1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
